// File: rtl/spike_event_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : qif_pkg
// Brief   : Shared widths, default sizes and helpers for the spike encoder.
// Rev     : 1.0  initial release
// ============================================================================
package qif_pkg;

    localparam int TS_W      = 16;
    localparam int V_W       = 8;
    localparam int EVT_W     = TS_W + V_W;
    localparam int DEPTH_DEF = 4;
    localparam int WIN_DEF   = 256;

    function automatic logic [7:0] sat_inc8(input logic [7:0] a, input logic inc);
        return (inc && (a != 8'hFF)) ? a + 8'd1 : a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spike_event_encoder_if.sv
`default_nettype none
// ============================================================================
// Module  : spike_event_encoder_if
// Brief   : Valid/ready event stream carrying {timestamp, v_sample}.
// Rev     : 1.0  initial release
// ============================================================================
interface spike_event_encoder_if #(
    parameter int DW = qif_pkg::EVT_W
);
    logic          evt_valid;
    logic          evt_ready;
    logic [DW-1:0] evt_data;

    modport master (output evt_valid, output evt_data, input  evt_ready);
    modport slave  (input  evt_valid, input  evt_data, output evt_ready);
endinterface
`default_nettype wire

// File: rtl/spike_event_encoder_fifo.sv
`default_nettype none
// ============================================================================
// Module  : event_fifo
// Brief   : First-word fall-through FIFO; push on full succeeds only with a pop.
// Rev     : 1.0  initial release
// ============================================================================
module event_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_push,
    input  wire logic                       i_pop,
    input  wire logic [W-1:0]               i_din,
    output logic      [W-1:0]               o_dout,
    output logic                            o_full,
    output logic                            o_empty,
    output logic      [$clog2(DEPTH):0]     o_count
);
    localparam int                c_AW    = $clog2(DEPTH);
    localparam int                c_CNT_W = c_AW + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [W-1:0]       r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr;
    logic [c_AW-1:0]    r_rd;
    logic [c_CNT_W-1:0] r_count;
    logic               w_pop_ok;
    logic               w_push_ok;

    assign o_full    = (r_count == c_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd];
    assign w_pop_ok  = i_pop & ~o_empty;
    // A full FIFO frees its head slot in the same cycle it is popped
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/spike_event_encoder.sv
`default_nettype none
// ============================================================================
// Module  : spike_event_encoder
// Brief   : Rising-edge spike detector, timestamped event FIFO and rate meter.
// Rev     : 1.0  initial release
// ============================================================================
module spike_event_encoder #(
    parameter int DEPTH = qif_pkg::DEPTH_DEF,
    parameter int TS_W  = qif_pkg::TS_W,
    parameter int WIN   = qif_pkg::WIN_DEF
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     spike_in,
    input  wire logic [7:0]               v_in,
    spike_event_encoder_if.master         evt,
    output logic      [$clog2(DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic      [7:0]               rate,
    output logic                          rate_valid
);
    import qif_pkg::*;

    localparam logic [15:0] c_WIN_LAST = 16'(WIN - 1);

    logic            r_spike_prev;
    logic [TS_W-1:0] r_ts;
    logic [15:0]     r_win;
    logic [7:0]      r_acc;
    logic [7:0]      r_rate;
    logic            r_rate_valid;
    logic            r_overflow;
    logic            w_evt;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [7:0]      w_acc_next;

    assign w_evt      = spike_in & ~r_spike_prev;
    assign w_pop      = evt.evt_valid & evt.evt_ready;
    assign w_acc_next = sat_inc8(r_acc, w_evt);

    assign evt.evt_valid = ~w_empty;
    assign overflow      = r_overflow;
    assign rate          = r_rate;
    assign rate_valid    = r_rate_valid;

    event_fifo #(
        .W     (TS_W + V_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst_n),
        .i_push  (w_evt),
        .i_pop   (w_pop),
        .i_din   ({r_ts, v_in}),
        .o_dout  (evt.evt_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_spike_prev <= 1'b0;
            r_ts         <= '0;
            r_win        <= '0;
            r_acc        <= '0;
            r_rate       <= '0;
            r_rate_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_spike_prev <= spike_in;
            r_ts         <= r_ts + 1'b1;
            // Window close: an event landing in the last cycle still counts
            if (r_win == c_WIN_LAST) begin
                r_win        <= '0;
                r_rate       <= w_acc_next;
                r_rate_valid <= 1'b1;
                r_acc        <= '0;
            end else begin
                r_win        <= r_win + 16'd1;
                r_rate_valid <= 1'b0;
                r_acc        <= w_acc_next;
            end
            if (w_evt && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spike_event_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_spike_event_encoder
// Brief   : Directed self-checking bench for the spike event encoder.
// Rev     : 1.0  initial release
// ============================================================================
module tb_spike_event_encoder;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        spike_in = 1'b0;
    logic        spike2   = 1'b0;
    logic [7:0]  v_in     = 8'd0;
    logic [15:0] tsm      = 16'd0;

    logic [2:0]  fifo_count;
    logic        overflow;
    logic [7:0]  rate;
    logic        rate_valid;
    logic [1:0]  fifo_count2;
    logic        overflow2;
    logic [7:0]  rate2;
    logic        rate_valid2;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    // Reference timestamp: equals the DUT counter between rising edges
    always @(posedge clk) tsm <= rst_n ? 16'd0 : tsm + 16'd1;

    spike_event_encoder_if #(.DW(24)) u_if ();
    spike_event_encoder_if #(.DW(24)) u_if2 ();

    spike_event_encoder #(.DEPTH(4), .TS_W(16), .WIN(256)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spike_in   (spike_in),
        .v_in       (v_in),
        .evt        (u_if.master),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .rate       (rate),
        .rate_valid (rate_valid)
    );

    spike_event_encoder #(.DEPTH(2), .TS_W(16), .WIN(1024)) u_dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .spike_in   (spike2),
        .v_in       (v_in),
        .evt        (u_if2.master),
        .fifo_count (fifo_count2),
        .overflow   (overflow2),
        .rate       (rate2),
        .rate_valid (rate_valid2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic spike1(input logic [7:0] v, output logic [15:0] ts);
        spike_in = 1'b1;
        v_in     = v;
        ts       = tsm;
        @(negedge clk);
        spike_in = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] ts;
        logic [15:0] ts_new;
        logic [15:0] exp_ts [4];
        int          nv;
        int          n;
        int          held_bad;

        u_if.evt_ready  = 1'b1;
        u_if2.evt_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", u_if.evt_valid, 1'b0);
        chk("rst_count", fifo_count, 3'd0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_rate", rate, 8'd0);
        chk("rst_rvalid", rate_valid, 1'b0);
        rst_n = 1'b0;

        // Single spike at timestamp 10
        repeat (10) @(negedge clk);
        spike_in = 1'b1;
        v_in     = 8'd50;
        @(negedge clk);
        chk("one_valid", u_if.evt_valid, 1'b1);
        chk("one_data", u_if.evt_data, {16'd10, 8'd50});
        chk("one_count", fifo_count, 3'd1);
        spike_in = 1'b0;
        @(negedge clk);
        chk("one_valid_after", u_if.evt_valid, 1'b0);
        chk("one_count_after", fifo_count, 3'd0);

        // Spike high through reset release, held 5 cycles: one event at ts 0
        spike_in = 1'b1;
        v_in     = 8'd77;
        do_reset();
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (u_if.evt_valid) nv++;
            if (i == 0) chk("hold_data", u_if.evt_data, {16'd0, 8'd77});
            if (i == 4) spike_in = 1'b0;
        end
        chk("hold_events", nv, 1);
        n = 0;
        while (!rate_valid && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("hold_rvalid", rate_valid, 1'b1);
        chk("hold_rate", rate, 8'd1);

        // Spikes every 8 cycles from window cycle 0
        n        = 0;
        held_bad = 0;
        do begin
            spike_in = (tsm[2:0] == 3'd0);
            @(negedge clk);
            n++;
            if (!rate_valid && rate != 8'd1) held_bad++;
        end while (!rate_valid && n < 400);
        spike_in = 1'b0;
        chk("win_len", n, 256);
        chk("win_rate", rate, 8'd32);
        chk("win_hold", held_bad, 0);
        @(negedge clk);
        chk("win_pulse_once", rate_valid, 1'b0);
        chk("win_rate_held", rate, 8'd32);

        // 300 events in one 1024-cycle window saturate at 255
        do_reset();
        chk("rst_rate_clear", rate, 8'd0);
        for (int i = 0; i < 600; i++) begin
            spike2 = ~spike2;
            @(negedge clk);
        end
        spike2 = 1'b0;
        n = 0;
        while (!rate_valid2 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        chk("sat_rvalid", rate_valid2, 1'b1);
        chk("sat_rate", rate2, 8'd255);

        // Six spikes into a stalled 4-deep FIFO
        do_reset();
        u_if.evt_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            spike1(8'(10 + i), ts);
            if (i < 4) exp_ts[i] = ts;
        end
        chk("ovf_count", fifo_count, 3'd4);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_head_stable", u_if.evt_data, {exp_ts[0], 8'd10});
        u_if.evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_drain", u_if.evt_data, {exp_ts[i], 8'(10 + i)});
            @(negedge clk);
        end
        chk("ovf_empty", u_if.evt_valid, 1'b0);
        chk("ovf_sticky", overflow, 1'b1);

        // Push and pop together on a full FIFO
        do_reset();
        u_if.evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            spike1(8'(20 + i), ts);
            exp_ts[i] = ts;
        end
        chk("full_count", fifo_count, 3'd4);
        spike_in       = 1'b1;
        v_in           = 8'd99;
        ts_new         = tsm;
        u_if.evt_ready = 1'b1;
        @(negedge clk);
        spike_in       = 1'b0;
        u_if.evt_ready = 1'b0;
        chk("full_pp_count", fifo_count, 3'd4);
        chk("full_pp_ovf", overflow, 1'b0);
        u_if.evt_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            chk("full_pp_drain", u_if.evt_data, {exp_ts[i], 8'(20 + i)});
            @(negedge clk);
        end
        chk("full_pp_last", u_if.evt_data, {ts_new, 8'd99});
        @(negedge clk);
        chk("full_pp_empty", u_if.evt_valid, 1'b0);

        // Reset with three entries queued
        do_reset();
        u_if.evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) spike1(8'(30 + i), ts);
        chk("flush_pre", fifo_count, 3'd3);
        rst_n    = 1'b1;
        spike_in = 1'b1;
        v_in     = 8'd66;
        @(negedge clk);
        chk("flush_valid", u_if.evt_valid, 1'b0);
        chk("flush_count", fifo_count, 3'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("flush_new_valid", u_if.evt_valid, 1'b1);
        chk("flush_new_count", fifo_count, 3'd1);
        chk("flush_new_data", u_if.evt_data, {16'd0, 8'd66});
        spike_in       = 1'b0;
        u_if.evt_ready = 1'b1;
        @(negedge clk);
        chk("flush_drained", u_if.evt_valid, 1'b0);
        chk("flush_drained_count", fifo_count, 3'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spike_event_encoder.md
SPIKE_EVENT_ENCODER -- requirements
Module: spike_event_encoder

Interface
REQ-001 Parameter DEPTH, default 4: event FIFO depth in entries; power of two, 2 to 16.
REQ-002 Parameter TS_W, default 16: timestamp width in bits.
REQ-003 Parameter WIN, default 256: rate window length in clock cycles; 2 to 65535.
REQ-004 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 Port rst_n, input, 1: synchronous active-high reset; name kept per codebase convention, asserted when 1.
REQ-006 Port spike_in, input, 1: spike level from the QIF neuron stage.
REQ-007 Port v_in, input, 8: signed membrane value from the QIF neuron stage.
REQ-008 Port evt_ready, input, 1: downstream accepts the head event.
REQ-009 Port evt_valid, output, 1: the FIFO holds at least one event.
REQ-010 Port evt_data, output, TS_W+8: head event, {timestamp, v_sample}, timestamp in the MSBs.
REQ-011 Port fifo_count, output, clog2(DEPTH)+1: number of occupied entries.
REQ-012 Port overflow, output, 1: sticky flag set when an event is dropped.
REQ-013 Port rate, output, 8: spike count of the last completed window.
REQ-014 Port rate_valid, output, 1: one-cycle pulse when rate updates.

Function
REQ-015 Free-running TS_W-bit timestamp counter shall increment every cycle and wrap from all-ones to 0.
REQ-016 Event shall be detected when spike_in=1 and the registered previous spike_in=0; a level held high for N cycles counts as one event.
REQ-017 On a detected event in cycle t, entry {ts(t), v_in(t)} shall be pushed; evt_valid and evt_data shall reflect it at t+1 when the FIFO was empty.
REQ-018 FIFO shall be first-word fall-through: evt_valid = (fifo_count != 0); evt_data = oldest entry; evt_data is don't-care when evt_valid=0.
REQ-019 Pop shall occur when evt_valid=1 and evt_ready=1 in the same cycle; evt_ready while empty has no effect.
REQ-020 Push on full with simultaneous pop shall succeed; fifo_count unchanged; no overflow.
REQ-021 Push on full without pop shall drop the new event, keep the stored entries, and set overflow; overflow clears only on reset.
REQ-022 Simultaneous push and pop on a non-full, non-empty FIFO shall leave fifo_count unchanged.
REQ-023 evt_data shall hold stable while evt_valid=1 and evt_ready=0.
REQ-024 Window counter shall count 0 to WIN-1 and wrap; the spike accumulator shall count detected events, saturating at 255, including dropped events.
REQ-025 In the cycle the window counter equals WIN-1, rate shall load the accumulator value plus any event in that cycle (saturated), rate_valid shall pulse in the following cycle aligned with the new rate, and the accumulator shall clear to 0.
REQ-026 rate shall hold its value between updates.

Reset
REQ-027 While rst_n=1 at a clock edge: timestamp, window counter, accumulator, previous-spike register, FIFO pointers, fifo_count, overflow, rate, and rate_valid shall go to 0; evt_valid shall be 0.
REQ-028 Reset mid-operation shall flush all FIFO contents; no entry present before reset shall appear afterwards.
REQ-029 Since the previous-spike register resets to 0, spike_in=1 in the first cycle after reset release shall count as an event with timestamp 0.

Structure
REQ-030 Package qif_pkg shall hold TS_W, the event width (TS_W+8), and the default DEPTH and WIN constants.
REQ-031 FIFO storage and pointers shall be one sub-module, event_fifo, parameterised by width and depth, with push/pop/full/empty/count ports.
REQ-032 Edge detection, timestamp, and rate logic shall reside in the top module.

Verification
REQ-033 Reset, then a single one-cycle spike at timestamp 10 with v_in=50 and evt_ready=1 -> evt_valid high one cycle; evt_data={16'd10, 8'd50}; fifo_count returns to 0.
REQ-034 spike_in held high for 5 cycles -> exactly one event; accumulator +1.
REQ-035 evt_ready=0, 6 isolated spikes with DEPTH=4 -> fifo_count=4; overflow=1; the first 4 timestamps are drained in order once evt_ready=1.
REQ-036 FIFO full, spike edge and evt_ready=1 in the same cycle -> count stays 4; overflow stays 0; the new entry appears last.
REQ-037 WIN=256 with spikes every 8 cycles starting at cycle 0 -> rate=32; rate_valid pulses once per 256 cycles; 300 spikes in a window -> rate=255.
REQ-038 Reset asserted with 3 entries queued -> the next cycle shows evt_valid=0, fifo_count=0, timestamp restarting at 0.
